// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// ----------------
// Shares the single-port data memory between the CPU load/store path and the
// host/debug port. Only one transaction is in flight at a time. When both
// ports request together, the grant goes round-robin. The CPU sees a
// combinational stall while its request is outstanding.
//
// Ports
//   i_clk, i_rst              clock; synchronous active-low reset
//   i_cpu_req/we/addr/wdata   CPU request (req held until o_cpu_ack)
//   o_cpu_rdata, o_cpu_ack    CPU read data register, one-cycle completion
//   o_cpu_stall               i_cpu_req & ~o_cpu_ack
//   i_host_req/we/addr/wdata  host/debug request
//   o_host_rdata, o_host_ack  host read data register, one-cycle completion
//   o_mem_en/we/addr/wdata    memory strobe (one cycle per transaction)
//                             and latched command fields
//   i_mem_rdata               memory read data, valid RD_LAT cycles after o_mem_en
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | sample requests, pick a winner, latch its command
// ISSUE  | drive o_mem_en for one cycle from the latched command
// WAIT   | count down the read latency, capture read data on the last count
// ACK    | pulse the granted port's ack; requests are not sampled here

module data_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack,
  output logic              o_cpu_stall,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_host_ack,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_last_host;  // 1 = host won the previous grant
  logic                r_gnt_host;   // owner of the transaction in flight
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_host_rdata;

  logic                w_grant;
  logic                w_grant_host;
  logic                w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and grant decision
  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_grant_host = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cpu_req || i_host_req) begin
          w_grant = 1'b1;
          // On a tie the port that did not win last time gets the memory.
          w_grant_host = (i_cpu_req && i_host_req) ? ~r_last_host : i_host_req;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = r_we ? S_ACK : S_WAIT;
      S_WAIT:  if (w_cnt_last) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_mem_en   = 1'b0;
    o_mem_we   = 1'b0;
    o_cpu_ack  = 1'b0;
    o_host_ack = 1'b0;
    case (r_state)
      S_ISSUE: begin
        o_mem_en = 1'b1;
        o_mem_we = r_we;
      end
      S_ACK: begin
        o_cpu_ack  = ~r_gnt_host;
        o_host_ack = r_gnt_host;
      end
      default: ;
    endcase
  end

  // Command latch, latency counter and per-port read data registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_last_host  <= 1'b1;
      r_gnt_host   <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_gnt_host  <= w_grant_host;
        r_last_host <= w_grant_host;
        r_we        <= w_grant_host ? i_host_we    : i_cpu_we;
        r_addr      <= w_grant_host ? i_host_addr  : i_cpu_addr;
        r_wdata     <= w_grant_host ? i_host_wdata : i_cpu_wdata;
      end

      if (r_state == S_ISSUE && !r_we) begin
        r_cnt <= CNT_W'(RD_LAT);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      // The last WAIT cycle is exactly RD_LAT cycles after the strobe.
      if (r_state == S_WAIT && w_cnt_last) begin
        if (r_gnt_host) begin
          r_host_rdata <= i_mem_rdata;
        end else begin
          r_cpu_rdata <= i_mem_rdata;
        end
      end
    end
  end

  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_host_rdata = r_host_rdata;
  assign o_cpu_stall  = i_cpu_req & ~o_cpu_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter. Two instances: index 0 with RD_LAT=1, index 1
// with RD_LAT=3, each with its own memory model. A transaction-timeline model
// predicts every output each cycle; directed tests add literal expectations.

module tb_data_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic [DW-1:0] JUNK = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic          rst        [2];
  logic          cpu_req    [2];
  logic          cpu_we     [2];
  logic [AW-1:0] cpu_addr   [2];
  logic [DW-1:0] cpu_wdata  [2];
  logic [DW-1:0] cpu_rdata  [2];
  logic          cpu_ack    [2];
  logic          cpu_stall  [2];
  logic          host_req   [2];
  logic          host_we    [2];
  logic [AW-1:0] host_addr  [2];
  logic [DW-1:0] host_wdata [2];
  logic [DW-1:0] host_rdata [2];
  logic          host_ack   [2];
  logic          mem_en     [2];
  logic          mem_we     [2];
  logic [AW-1:0] mem_addr   [2];
  logic [DW-1:0] mem_wdata  [2];
  logic [DW-1:0] mem_rdata  [2];

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst[0]),
    .i_cpu_req(cpu_req[0]), .i_cpu_we(cpu_we[0]), .i_cpu_addr(cpu_addr[0]),
    .i_cpu_wdata(cpu_wdata[0]), .o_cpu_rdata(cpu_rdata[0]), .o_cpu_ack(cpu_ack[0]),
    .o_cpu_stall(cpu_stall[0]),
    .i_host_req(host_req[0]), .i_host_we(host_we[0]), .i_host_addr(host_addr[0]),
    .i_host_wdata(host_wdata[0]), .o_host_rdata(host_rdata[0]), .o_host_ack(host_ack[0]),
    .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
    .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0])
  );

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst[1]),
    .i_cpu_req(cpu_req[1]), .i_cpu_we(cpu_we[1]), .i_cpu_addr(cpu_addr[1]),
    .i_cpu_wdata(cpu_wdata[1]), .o_cpu_rdata(cpu_rdata[1]), .o_cpu_ack(cpu_ack[1]),
    .o_cpu_stall(cpu_stall[1]),
    .i_host_req(host_req[1]), .i_host_we(host_we[1]), .i_host_addr(host_addr[1]),
    .i_host_wdata(host_wdata[1]), .o_host_rdata(host_rdata[1]), .o_host_ack(host_ack[1]),
    .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
    .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] init_val(input int k, input int a);
    if (k == 1 && a == 32'h20) return 32'h1234_5678;
    if (a == 1) return 32'h1111_0001;
    if (a == 2) return 32'h2222_0002;
    return {16'hA5A5, 8'(k), 8'(a)};
  endfunction

  // Memory models: read data appears exactly RD_LAT cycles after the strobe,
  // junk at all other times.
  logic [DW-1:0] bmem [2][256];
  bit            bmem_ready = 1'b0;
  logic [DW-1:0] rp0;
  logic [DW-1:0] rp1 [3];

  always @(posedge clk) begin
    if (!bmem_ready) begin
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 256; a++) bmem[k][a] <= init_val(k, a);
      bmem_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++)
        if (mem_en[k] && mem_we[k]) bmem[k][mem_addr[k]] <= mem_wdata[k];
    end
    rp0    <= mem_en[0] ? bmem[0][mem_addr[0]] : JUNK;
    rp1[0] <= mem_en[1] ? bmem[1][mem_addr[1]] : JUNK;
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign mem_rdata[0] = rp0;
  assign mem_rdata[1] = rp1[2];

  int en_cnt [2] = '{0, 0};
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      if (mem_en[k]) en_cnt[k] <= en_cnt[k] + 1;
  end

  task automatic chk(input string nm, input int k, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", nm, k, cyc, act, exp);
    end
  endtask

  // Timeline model: t counts cycles since the sampling cycle (t=0).
  // Strobe at t=1; write ack at t=2; read ack at t=2+L with data captured
  // from memory at the end of t=1+L; idle again the cycle after the ack.
  bit            m_on  [2];
  int            m_t   [2];
  bit            m_gh  [2];
  bit            m_we  [2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wd  [2];
  bit            m_last_host [2];
  logic [DW-1:0] m_crd [2];
  logic [DW-1:0] m_hrd [2];
  logic [DW-1:0] shadow [2][256];

  task automatic model_step(input int k);
    int at;
    at = m_we[k] ? 2 : 2 + lat(k);
    if (m_on[k] && m_t[k] == 1 && m_we[k]) shadow[k][m_addr[k]] = m_wd[k];
    if (!rst[k]) begin
      m_on[k] = 1'b0;
      m_t[k] = 0;
      m_last_host[k] = 1'b1;
      m_crd[k] = '0;
      m_hrd[k] = '0;
    end else if (m_on[k]) begin
      if (!m_we[k] && m_t[k] == 1 + lat(k)) begin
        if (m_gh[k]) m_hrd[k] = shadow[k][m_addr[k]];
        else         m_crd[k] = shadow[k][m_addr[k]];
      end
      if (m_t[k] == at) m_on[k] = 1'b0;
      else m_t[k] = m_t[k] + 1;
    end else if (cpu_req[k] || host_req[k]) begin
      m_gh[k] = (cpu_req[k] && host_req[k]) ? !m_last_host[k] : host_req[k];
      m_last_host[k] = m_gh[k];
      m_we[k]   = m_gh[k] ? host_we[k]    : cpu_we[k];
      m_addr[k] = m_gh[k] ? host_addr[k]  : cpu_addr[k];
      m_wd[k]   = m_gh[k] ? host_wdata[k] : cpu_wdata[k];
      m_on[k] = 1'b1;
      m_t[k] = 1;
    end
  endtask

  task automatic compare(input int k);
    int at;
    bit en, ca, ha;
    at = m_we[k] ? 2 : 2 + lat(k);
    en = m_on[k] && m_t[k] == 1;
    ca = m_on[k] && m_t[k] == at && !m_gh[k];
    ha = m_on[k] && m_t[k] == at && m_gh[k];
    chk("mem_en", k, 32'(mem_en[k]), 32'(en));
    if (en) begin
      chk("mem_we", k, 32'(mem_we[k]), 32'(m_we[k]));
      chk("mem_addr", k, 32'(mem_addr[k]), 32'(m_addr[k]));
      if (m_we[k]) chk("mem_wdata", k, mem_wdata[k], m_wd[k]);
    end
    chk("cpu_ack", k, 32'(cpu_ack[k]), 32'(ca));
    chk("host_ack", k, 32'(host_ack[k]), 32'(ha));
    chk("cpu_stall", k, 32'(cpu_stall[k]), 32'(cpu_req[k] && !ca));
    chk("cpu_rdata", k, cpu_rdata[k], m_crd[k]);
    chk("host_rdata", k, host_rdata[k], m_hrd[k]);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_on[k] = 1'b0; m_t[k] = 0; m_gh[k] = 1'b0; m_we[k] = 1'b0;
      m_addr[k] = '0; m_wd[k] = '0; m_last_host[k] = 1'b1;
      m_crd[k] = '0; m_hrd[k] = '0;
      for (int a = 0; a < 256; a++) shadow[k][a] = init_val(k, a);
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
      @(negedge clk);
      for (int k = 0; k < 2; k++) compare(k);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int k, input bit host, output int n,
                          output logic [DW-1:0] rd);
    n = 0;
    @(negedge clk);
    while (!(host ? host_ack[k] : cpu_ack[k]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    rd = host ? host_rdata[k] : cpu_rdata[k];
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout[%0d]: no ack within 50 cycles, one required", k);
    end
  endtask

  task automatic xact(input int k, input bit host, input bit we,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      output int n, output logic [DW-1:0] rd);
    tick();
    if (host) begin
      host_req[k] = 1'b1; host_we[k] = we; host_addr[k] = addr; host_wdata[k] = wd;
    end else begin
      cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wd;
    end
    wait_ack(k, host, n, rd);
    tick();
    if (host) host_req[k] = 1'b0;
    else      cpu_req[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n, acks, e0;
    logic [DW-1:0] d;
    int            order [4];
    logic [DW-1:0] dat   [4];
    logic [DW-1:0] other [4];

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      host_req[k] = 1'b0; host_we[k] = 1'b0; host_addr[k] = '0; host_wdata[k] = '0;
    end

    // Reset held with both ports requesting, then CPU wins the first tie.
    cpu_req[0] = 1'b1; cpu_addr[0] = 8'h05;
    host_req[0] = 1'b1; host_addr[0] = 8'h06;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mem_en", 0, 32'(mem_en[0]), 32'h0);
    chk("rst_mem_addr", 0, 32'(mem_addr[0]), 32'h0);
    chk("rst_mem_wdata", 0, mem_wdata[0], 32'h0);
    chk("rst_cpu_ack", 0, 32'(cpu_ack[0]), 32'h0);
    chk("rst_host_rdata", 0, host_rdata[0], 32'h0);
    tick(); rst[0] = 1'b1;
    @(negedge clk);
    chk("rel_en_c0", 0, 32'(mem_en[0]), 32'h0);
    tick();
    @(negedge clk);
    chk("rel_en_c1", 0, 32'(mem_en[0]), 32'h1);
    chk("rel_winner_addr", 0, 32'(mem_addr[0]), 32'h05);
    tick(); cpu_req[0] = 1'b0; host_req[0] = 1'b0;
    wait_ack(0, 1'b0, n, d);
    chk("rel_ack_delay", 0, 32'(n), 32'd1);
    tick();

    // CPU write then read back, RD_LAT=1.
    xact(0, 1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF, n, d);
    chk("wr_latency", 0, 32'(n), 32'd2);
    xact(0, 1'b0, 1'b0, 8'h10, 32'h0, n, d);
    chk("rd_latency", 0, 32'(n), 32'd3);
    chk("rd_data", 0, d, 32'hDEAD_BEEF);

    // Contention after a fresh reset: strict alternation starting with CPU.
    tick(); rst[0] = 1'b0;
    tick(); rst[0] = 1'b1;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 8'h01;
    host_req[0] = 1'b1; host_we[0] = 1'b0; host_addr[0] = 8'h02;
    acks = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      @(negedge clk);
      if (cpu_ack[0]) begin
        order[acks] = 0; dat[acks] = cpu_rdata[0]; other[acks] = host_rdata[0]; acks++;
      end else if (host_ack[0]) begin
        order[acks] = 1; dat[acks] = host_rdata[0]; other[acks] = cpu_rdata[0]; acks++;
      end
    end
    tick(); cpu_req[0] = 1'b0; host_req[0] = 1'b0;
    chk("cont_acks", 0, 32'(acks), 32'd4);
    if (acks == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("cont_order", i, 32'(order[i]), 32'(i % 2));
        chk("cont_data", i, dat[i], (i % 2 == 0) ? 32'h1111_0001 : 32'h2222_0002);
      end
      chk("cont_host_hold0", 0, other[0], 32'h0);
      chk("cont_cpu_hold1", 0, other[1], 32'h1111_0001);
      chk("cont_host_hold2", 0, other[2], 32'h2222_0002);
    end

    // RD_LAT=3 host read.
    tick(); rst[1] = 1'b1;
    e0 = en_cnt[1];
    xact(1, 1'b1, 1'b0, 8'h20, 32'h0, n, d);
    chk("lat3_latency", 1, 32'(n), 32'd5);
    chk("lat3_data", 1, d, 32'h1234_5678);
    chk("lat3_en_count", 1, 32'(en_cnt[1] - e0), 32'd1);

    // Request dropped and address changed during ISSUE.
    e0 = en_cnt[0];
    tick(); cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 8'h01;
    tick(); cpu_req[0] = 1'b0; cpu_addr[0] = 8'h31;
    @(negedge clk);
    chk("edge_issue_en", 0, 32'(mem_en[0]), 32'h1);
    chk("edge_issue_addr", 0, 32'(mem_addr[0]), 32'h01);
    acks = 0; d = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cpu_ack[0]) begin acks++; d = cpu_rdata[0]; end
    end
    tick();
    chk("edge_ack_count", 0, 32'(acks), 32'd1);
    chk("edge_data", 0, d, 32'h1111_0001);
    chk("edge_en_count", 0, 32'(en_cnt[0] - e0), 32'd1);

    // Reset during WAIT aborts the read; a fresh write then completes.
    tick(); host_req[1] = 1'b1; host_we[1] = 1'b0; host_addr[1] = 8'h20;
    tick(); host_req[1] = 1'b0;
    tick(); rst[1] = 1'b0;
    tick(); rst[1] = 1'b1;
    @(negedge clk);
    chk("midrst_host_rdata", 1, host_rdata[1], 32'h0);
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (host_ack[1]) acks++;
    end
    chk("midrst_no_ack", 1, 32'(acks), 32'd0);
    xact(1, 1'b1, 1'b1, 8'h40, 32'h0BAD_CAFE, n, d);
    chk("midrst_wr_latency", 1, 32'(n), 32'd2);
    xact(1, 1'b1, 1'b0, 8'h40, 32'h0, n, d);
    chk("midrst_rd_latency", 1, 32'(n), 32'd5);
    chk("midrst_rd_data", 1, d, 32'h0BAD_CAFE);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
